// File: rtl/sequential_divider.sv
// Radix-2 restoring divider for l.div / l.divu: one trial subtraction per cycle,
// with signed operands handled through magnitudes and a final sign fixup.
module sequential_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             isSigned,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divByZero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [2:0] {StIdle, StLoad, StIterate, StFixup, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] dvd_q;    // raw dividend, kept for the divide-by-zero remainder
  logic [WIDTH-1:0] dvs_q;
  logic             signed_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [WIDTH-1:0] a_q;      // dividend magnitude, shifted out as quotient bits shift in
  logic [WIDTH-1:0] b_q;      // divisor magnitude (2^(WIDTH-1) fits unsigned)
  logic [WIDTH-1:0] p_q;      // partial remainder, always < b_q between iterations
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    shifted = {p_q, a_q[WIDTH-1]};
    trial   = shifted - {1'b0, b_q};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      dvd_q     <= '0;
      dvs_q     <= '0;
      signed_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      divByZero <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            dvd_q    <= dividend;
            dvs_q    <= divisor;
            signed_q <= isSigned;
            busy     <= 1'b1;
            state_q  <= StLoad;
          end
        end
        StLoad: begin
          a_q       <= (signed_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
          b_q       <= (signed_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
          neg_quo_q <= signed_q && (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
          neg_rem_q <= signed_q && dvd_q[WIDTH-1];
          p_q       <= '0;
          cnt_q     <= '0;
          state_q   <= (dvs_q == '0) ? StFixup : StIterate;
        end
        StIterate: begin
          if (!trial[WIDTH]) begin
            p_q <= trial[WIDTH-1:0];
            a_q <= {a_q[WIDTH-2:0], 1'b1};
          end else begin
            p_q <= shifted[WIDTH-1:0];
            a_q <= {a_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_q   <= '0;
            state_q <= StFixup;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StFixup: begin
          if (dvs_q == '0) begin
            quotient  <= '1;
            remainder <= dvd_q;
            divByZero <= 1'b1;
          end else begin
            quotient  <= neg_quo_q ? -a_q : a_q;
            remainder <= neg_rem_q ? -p_q : p_q;
            divByZero <= 1'b0;
          end
          busy    <= 1'b0;
          done    <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_divider.sv
// Scoreboard bench for sequential_divider: driver pushes expected results, a monitor
// pops and compares them (value and latency) on every done pulse.
module tb_sequential_divider;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic         isSigned;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         divByZero;

  sequential_divider #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .isSigned  (isSigned),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .divByZero (divByZero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           done_edge;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   total = 0;
  int   passed = 0;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("divByZero", 32'(divByZero), 32'(e.dbz));
        check("done_cycle", 32'(edge_cnt), 32'(e.done_edge));
        check("busy_in_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz,
                        input bit poke);
    exp_t e;
    int   waited;
    @(negedge clock);
    start    = 1'b1;
    isSigned = sgn;
    dividend = a;
    divisor  = b;
    @(posedge clock);
    #1;
    e.q         = q;
    e.r         = r;
    e.dbz       = dbz;
    e.done_edge = edge_cnt + ((b == '0) ? 2 : W + 2);
    sb.push_back(e);
    @(negedge clock);
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h0000_0000;
    check("busy_after_start", 32'(busy), 32'd1);
    if (poke) begin
      // Re-issue start with different operands mid-operation; must be ignored.
      repeat (4) @(negedge clock);
      start = 1'b1; isSigned = 1'b1; dividend = 32'd7; divisor = 32'd0;
      @(negedge clock);
      start = 1'b0;
      repeat (14) @(negedge clock);
      start = 1'b1; isSigned = 1'b0; dividend = 32'd99; divisor = 32'd3;
      @(negedge clock);
      start = 1'b0;
    end
    waited = 0;
    while (!done && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    if (!done) begin
      check("done_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
    end else begin
      @(negedge clock);
      check("held_quotient", quotient, q);
      check("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; isSigned = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_dbz", 32'(divByZero), 32'd0);
    reset = 1'b0;

    run_op(1'b0, 32'd100,       32'd7,          32'd14,        32'd2,         1'b0, 1'b0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 32'd0,         1'b0, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 32'd0,         1'b0, 1'b0);
    run_op(1'b0, 32'h0000_1234, 32'd0,          32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1'b0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1'b0);
    run_op(1'b1, 32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'd1,         1'b0, 1'b0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(1'b0, 32'h8000_0000, 32'd3,          32'h2AAA_AAAA, 32'd2,         1'b0, 1'b0);
    run_op(1'b0, 32'd5,         32'd9,          32'd0,         32'd5,         1'b0, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'd2,          32'hC000_0000, 32'd0,         1'b0, 1'b0);
    run_op(1'b0, 32'd1000,      32'd10,         32'd100,       32'd0,         1'b0, 1'b1);

    // Abort an operation with reset; no done may follow.
    @(negedge clock);
    start = 1'b1; isSigned = 1'b0; dividend = 32'd500; divisor = 32'd7;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quotient", quotient, 32'd0);
    check("abort_remainder", remainder, 32'd0);
    check("abort_dbz", 32'(divByZero), 32'd0);
    repeat (40) @(negedge clock);

    run_op(1'b0, 32'h0000_FFFF, 32'h0000_0100, 32'h0000_00FF, 32'h0000_00FF, 1'b0, 1'b0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
